muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit; the parametrised, multi-cycle successor to the single-cycle combinational ALU.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle, with valid/ready handshakes on the request and result sides.
- Sits beside the ALU in the execute stage; the core stalls while busy is high.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_datapath.sv | 45 ++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Operation encodings match the funct3 field of the M extension.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    function automatic logic op_is_div(md_op_e o);
        return o[2];
    endfunction

    function automatic logic a_is_signed(md_op_e o);
        return o inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic b_is_signed(md_op_e o);
        return o inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared 2*XLEN accumulator: radix-2 shift-add multiply or restoring divide.
// Multiply leaves the product in acc; divide leaves {remainder, quotient}.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0] opnd;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted_hi;
    logic [XLEN:0]   diff;

    always_comb begin
        add_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted_hi = acc[2*XLEN-1:XLEN-1];
        diff       = shifted_hi - {1'b0, opnd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            // multiplier / dividend enter the low half and shift out as the result builds
            acc  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd <= is_div ? mag_b : mag_a;
        end else if (step) begin
            if (!is_div)
                acc <= {add_sum, acc[XLEN-1:1]};
            else if (!diff[XLEN])
                acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc <= {shifted_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, handshakes
// and divide special cases around a one-bit-per-cycle datapath.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// PREP  | operands to magnitudes, special divide cases detected
// CALC  | XLEN shift-add / restoring-divide iterations
// FIX   | sign correction and result selection (or special-case result)
// DONE  | result presented until out_ready
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  md_op_e          op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    input  logic            flush
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_e         state;
    md_op_e            op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              sa_q, sb_q;
    logic              spec_q;
    logic [CW-1:0]     cnt;

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_val;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        mag_a    = sa_q ? -a_q : a_q;
        mag_b    = sb_q ? -b_q : b_q;
        div_zero = (b_q == '0);
        div_ovf  = (op_q == DIV || op_q == REM) &&
                   (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
        special  = op_is_div(op_q) && (div_zero || div_ovf);
        if (div_zero)
            spec_val = (op_q == DIV || op_q == DIVU) ? '1 : a_q;
        else
            spec_val = (op_q == DIV) ? a_q : '0;
    end

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc : acc;
        quot_fix = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 fix_val = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_val = quot_fix;
            default:             fix_val = rem_fix;
        endcase
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (state == PREP),
        .step   (state == CALC),
        .is_div (op_is_div(op_q)),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= MUL;
            a_q       <= '0;
            b_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            spec_q    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush && state != IDLE) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q     <= op;
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        sa_q     <= operand_a[XLEN-1] & a_is_signed(op);
                        sb_q     <= operand_b[XLEN-1] & b_is_signed(op);
                        state    <= PREP;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                PREP: begin
                    cnt    <= '0;
                    spec_q <= special;
                    // special results still pass through FIX so both paths share the result register
                    state  <= special ? FIX : CALC;
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    result    <= spec_q ? spec_val : fix_val;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected results, a monitor
// pops and compares result and latency whenever out_valid rises.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy, flush;
    md_op_e      op;
    logic [31:0] operand_a, operand_b, result;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_flush;
    md_op_e      s_op;
    logic [15:0] s_a, s_b, s_result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy), .flush(flush)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
        .operand_a(s_a), .operand_b(s_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result), .busy(s_busy), .flush(s_flush)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic rdy_auto = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width 64-bit arithmetic, results taken modulo 2^32
    function automatic logic [31:0] model(md_op_e o, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (o)
            MUL:    begin p = ua * ub;  return p[31:0];  end
            MULH:   begin p = sa * sbv; return p[63:32]; end
            MULHSU: begin p = sa * ub;  return p[63:32]; end
            MULHU:  begin p = ua * ub;  return p[63:32]; end
            DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
            DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub;  return p[31:0]; end
            REM:    begin if (b == 0) return a;             p = sa % sbv; return p[31:0]; end
            default: begin if (b == 0) return a;            p = ua % ub;  return p[31:0]; end
        endcase
    endfunction

    function automatic int latency(md_op_e o, logic [31:0] a, logic [31:0] b);
        if (o inside {DIV, DIVU, REM, REMU} && b == 0)
            return 2;
        if (o inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 2;
        return XLEN + 2;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(md_op_e o, logic [31:0] a, logic [31:0] b, logic [31:0] exp, bit push);
        exp_t e;
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_issue", in_ready, 1);
        if (!in_ready) return;
        op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
        if (push) begin
            e.res = exp; e.lat = latency(o, a, b); e.acc_edge = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op = md_op_e'($urandom_range(0, 7));
        operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic wait_valid(string name);
        int t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, out_valid, 1);
    endtask

    // Monitor
    logic prev_ov = 1'b0;
    logic have_cur = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov  = 1'b0;
            have_cur = 1'b0;
        end else begin
            check("busy_vs_in_ready", busy, !in_ready);
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h with no request outstanding", result);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check("result", result, cur.res);
                    check("latency", cyc - cur.acc_edge, cur.lat);
                end
            end else if (out_valid && have_cur) begin
                check("result_hold", result, cur.res);
            end
            if (!out_valid) have_cur = 1'b0;
            prev_ov = out_valid;
        end
    end

    always @(negedge clk) if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);

    typedef struct {
        md_op_e      o;
        logic [31:0] a, b, r;
    } vec_t;

    vec_t dir[$];

    initial begin
        md_op_e      ro;
        logic [31:0] ra, rb;
        int          t, s_edge;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = MUL; operand_a = '0; operand_b = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_op = MUL; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        // low-word multiply with busy held through the calculation
        rdy_auto = 1'b1;
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        t = 0;
        while (!out_valid && t < 100) begin
            check("busy_during_calc", busy, 1);
            @(negedge clk);
            t++;
        end
        check("mul_completes", out_valid, 1);

        dir.push_back('{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        dir.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        dir.push_back('{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        dir.push_back('{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        dir.push_back('{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        dir.push_back('{DIVU,   32'd100,       32'd7,         32'd14});
        dir.push_back('{REMU,   32'd100,       32'd7,         32'd2});
        dir.push_back('{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF});
        dir.push_back('{REM,    32'd5,         32'd0,         32'd5});
        dir.push_back('{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        dir.push_back('{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        foreach (dir[i]) issue(dir[i].o, dir[i].a, dir[i].b, dir[i].r, 1);

        // backpressure in DONE, then back-to-back accept after the handshake
        t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        rdy_auto = 1'b0; out_ready = 1'b0;
        issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1);
        wait_valid("bp_reach_done");
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_out_valid_drop", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        issue(DIVU, 32'd1000, 32'd33, 32'd30, 1);
        check("next_accept_busy", busy, 1);
        rdy_auto = 1'b1;

        // flush blocks acceptance in IDLE
        t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        in_valid = 1'b1; flush = 1'b1; op = DIV; operand_a = 32'd9; operand_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", in_ready, 1);
        check("idle_flush_busy", busy, 0);

        // flush mid-divide: no result must ever appear
        issue(DIV, 32'd12345, 32'd17, 32'd0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        repeat (40) @(negedge clk);

        // reset mid-multiply
        issue(MUL, 32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);

        // XLEN=16 instance
        s_op = MUL; s_a = 16'h00FF; s_b = 16'h0101; s_in_valid = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        s_in_valid = 1'b0;
        t = 0;
        while (!s_out_valid && t < 100) begin @(negedge clk); t++; end
        check("x16_valid", s_out_valid, 1);
        check("x16_result", s_result, 16'hFFFF);
        check("x16_latency", cyc - s_edge, 18);

        // randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            ro = md_op_e'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ro, ra, rb, model(ro, ra, rb), 1);
        end

        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 500) begin @(negedge clk); t++; end
        check("drain_scoreboard", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
